mul_arbiter: RTL and testbench
==============================

MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter: W, default 4, operand width; result width is 2*W.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operand pair.
REQ-005 req0_a, req0_b  input  W each  requester 0 operands, unsigned.
REQ-006 req0_ready  output  1  requester 0 pair accepted this cycle when high with req0_valid.
REQ-007 req1_valid, req1_a, req1_b, req1_ready: same widths and meaning for requester 1.
REQ-008 rsp_valid  output  1  result register holds a product.
REQ-009 rsp_id  output  1  requester that owns the held product (0 or 1).
REQ-010 rsp_y  output  2*W  unsigned product a*b.
REQ-011 rsp_ready  input  1  consumer takes the response when high with rsp_valid.
REQ-012 cnt0, cnt1  output  8 each  number of accepted requests per requester.

Function
REQ-013 One shared combinational W x W multiplier; only the granted pair drives its inputs.
REQ-014 slot_free = !rsp_valid | rsp_ready; no grant is issued when slot_free is low.
REQ-015 Grant: one valid requester -> that requester; both valid -> requester != last_grant; none valid -> no grant, last_grant unchanged.
REQ-016 reqN_ready = slot_free & grant==N; combinational; never high for both in one cycle.
REQ-017 Accept (reqN_valid & reqN_ready) at edge k -> rsp_valid=1, rsp_y=a*b, rsp_id=N visible after edge k; latency 1 cycle.
REQ-018 last_grant updates to N on every accept only.
REQ-019 Back-to-back: response drain and new accept in the same cycle -> register loads the new product; rsp_valid stays 1.
REQ-020 Drain without accept -> rsp_valid=0 next cycle; rsp_y and rsp_id hold their last value.
REQ-021 Stall (rsp_valid & !rsp_ready) -> rsp_y, rsp_id, rsp_valid hold; both readies low.
REQ-022 cntN increments by 1 on each accept from N and wraps 255 -> 0.
REQ-023 Operands are unsigned; 0 x anything = 0; max (2^W-1)^2 fits in 2*W bits without truncation.
REQ-024 Requester inputs are sampled only in the accept cycle; changes while not granted have no effect.

Reset
REQ-025 rst_n low at an edge -> rsp_valid=0, rsp_id=0, rsp_y=0, cnt0=cnt1=0, last_grant=1 (requester 0 wins the first tie).
REQ-026 While rst_n is low, req0_ready and req1_ready are 0.
REQ-027 Reset during a held or stalled response discards it; no response is emitted after reset.

Structure
REQ-028 Package mul_arb_pkg holds the default W, the requester ID constants (ID0=0, ID1=1) and the counter width (8).
REQ-029 Sub-module mul_core: a purely combinational W x W -> 2*W unsigned multiplier, instantiated once.
REQ-030 The arbiter, result register and counters are in mul_arbiter; the arbiter has no FSM beyond last_grant and rsp_valid.

Verification
REQ-031 Single: req0 a=2, b=11, rsp_ready=1 -> 1 cycle later rsp_valid=1, rsp_y=22, rsp_id=0, cnt0=1.
REQ-032 Tie after reset: both valid (r0: 14x6, r1: 12x3), rsp_ready=1 -> responses 84/id0 then 36/id1 on consecutive cycles.
REQ-033 Stall: rsp_ready=0 for 3 cycles with a held 9x5=45 -> rsp_y stays 45, both readies 0; rsp_ready=1 -> next grant same cycle.
REQ-034 Boundary: 15x15 -> 225; 0x13 -> 0; 256 accepts from req1 -> cnt1 wraps to 0.
REQ-035 Reset while a response is held and stalled -> next cycle rsp_valid=0, counters 0, and a following tie grants req0.

Source files
------------

// File: rtl/mul_arb_pkg.sv
// Shared constants for the two-requester multiplier arbiter.
// Holds the default operand width, requester IDs and counter width.
package mul_arb_pkg;

  localparam int   DEFAULT_W = 4;
  localparam int   CNT_W     = 8;
  localparam logic ID0       = 1'b0;
  localparam logic ID1       = 1'b1;

endpackage

// File: rtl/mul_core.sv
// Purely combinational unsigned W x W -> 2*W multiplier.
// Operands are zero-extended first so the full product is kept.
module mul_core #(
  parameter int W = 4
) (
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [2*W-1:0] o_y
);

  assign o_y = (2*W)'(i_a) * (2*W)'(i_b);

endmodule

// File: rtl/mul_arbiter.sv
// Two requesters share one multiplier; round-robin on ties.
// Holds one result in a response register with a valid/ready drain handshake.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [W-1:0]     req0_a,
  input  logic [W-1:0]     req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [W-1:0]     req1_a,
  input  logic [W-1:0]     req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [2*W-1:0]   rsp_y,
  input  logic             rsp_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [2*W-1:0]   r_rsp_y;
  logic             r_last_grant;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic             w_slot_free;
  logic             w_gnt_id;
  logic             w_grant_en;
  logic [W-1:0]     w_op_a;
  logic [W-1:0]     w_op_b;
  logic [2*W-1:0]   w_prod;

  // A grant always targets a valid requester, so grant_en doubles as "accept".
  always_comb begin
    w_slot_free = ~r_rsp_valid | rsp_ready;
    w_gnt_id    = ID0;
    if (req0_valid & req1_valid)
      w_gnt_id = ~r_last_grant;
    else if (req1_valid)
      w_gnt_id = ID1;
    w_grant_en  = rst_n & w_slot_free & (req0_valid | req1_valid);
    req0_ready  = w_grant_en & (w_gnt_id == ID0);
    req1_ready  = w_grant_en & (w_gnt_id == ID1);
    w_op_a      = '0;
    w_op_b      = '0;
    if (w_grant_en) begin
      w_op_a = (w_gnt_id == ID1) ? req1_a : req0_a;
      w_op_b = (w_gnt_id == ID1) ? req1_b : req0_b;
    end
  end

  mul_core #(.W(W)) u_mul_core (
    .i_a (w_op_a),
    .i_b (w_op_b),
    .o_y (w_prod)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= ID0;
      r_rsp_y      <= '0;
      r_last_grant <= ID1;
      r_cnt0       <= '0;
      r_cnt1       <= '0;
    end else if (w_grant_en) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_id     <= w_gnt_id;
      r_rsp_y      <= w_prod;
      r_last_grant <= w_gnt_id;
      if (w_gnt_id == ID1)
        r_cnt1 <= r_cnt1 + CNT_W'(1);
      else
        r_cnt0 <= r_cnt0 + CNT_W'(1);
    end else if (rsp_ready) begin
      // Drain only clears valid; data and id stay for inspection.
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_y     = r_rsp_y;
  assign cnt0      = r_cnt0;
  assign cnt1      = r_cnt1;

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: directed cases plus randomized traffic
// compared against a transaction-level reference model.
module tb_mul_arbiter;

  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic           req0_valid;
  logic [W-1:0]   req0_a;
  logic [W-1:0]   req0_b;
  logic           req0_ready;
  logic           req1_valid;
  logic [W-1:0]   req1_a;
  logic [W-1:0]   req1_b;
  logic           req1_ready;
  logic           rsp_valid;
  logic           rsp_id;
  logic [2*W-1:0] rsp_y;
  logic           rsp_ready;
  logic [7:0]     cnt0;
  logic [7:0]     cnt1;

  int n_vec;
  int n_err;

  // Reference model state: held response, last winner, per-requester accept counts.
  int m_valid;
  int m_id;
  int m_y;
  int m_last;
  int m_cnt[2];

  mul_arbiter #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_y      (rsp_y),
    .rsp_ready  (rsp_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check readies, clock, update model, check outputs.
  task automatic apply(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                       input logic rr, input logic rn);
    int  win;
    int  slot;
    @(negedge clk);
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    rsp_ready  = rr; rst_n  = rn;
    #1;
    slot = (m_valid == 0 || rr) ? 1 : 0;
    win  = -1;
    if (v0 && v1)  win = 1 - m_last;
    else if (v0)   win = 0;
    else if (v1)   win = 1;
    check_eq("req0_ready", {31'd0, req0_ready}, (rn && slot == 1 && win == 0) ? 32'd1 : 32'd0);
    check_eq("req1_ready", {31'd0, req1_ready}, (rn && slot == 1 && win == 1) ? 32'd1 : 32'd0);
    @(posedge clk);
    #1;
    if (!rn) begin
      m_valid = 0; m_id = 0; m_y = 0; m_last = 1;
      m_cnt[0] = 0; m_cnt[1] = 0;
    end else if (win >= 0 && slot == 1) begin
      m_valid = 1;
      m_id    = win;
      m_y     = (win == 0) ? int'(a0) * int'(b0) : int'(a1) * int'(b1);
      m_last  = win;
      m_cnt[win] = (m_cnt[win] + 1) % 256;
    end else if (rr) begin
      m_valid = 0;
    end
    check_eq("rsp_valid", {31'd0, rsp_valid}, m_valid);
    check_eq("rsp_id",    {31'd0, rsp_id},    m_id);
    check_eq("rsp_y",     {24'd0, rsp_y},     m_y);
    check_eq("cnt0",      {24'd0, cnt0},      m_cnt[0]);
    check_eq("cnt1",      {24'd0, cnt1},      m_cnt[1]);
    $display("txn t=%0t rst_n=%0b v0=%0b %0dx%0d v1=%0b %0dx%0d rr=%0b -> valid=%0b id=%0d y=%0d c0=%0d c1=%0d",
             $time, rn, v0, a0, b0, v1, a1, b1, rr, rsp_valid, rsp_id, rsp_y, cnt0, cnt1);
  endtask

  task automatic do_reset();
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    m_valid = 0; m_id = 0; m_y = 0; m_last = 1; m_cnt[0] = 0; m_cnt[1] = 0;
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;

    // Reset state
    do_reset();
    check_eq("reset_valid", {31'd0, rsp_valid}, 0);
    check_eq("reset_y", {24'd0, rsp_y}, 0);

    // Single request from req0
    apply(1, 2, 11, 0, 0, 0, 1, 1);
    check_eq("single_y", {24'd0, rsp_y}, 22);
    check_eq("single_cnt0", {24'd0, cnt0}, 1);

    // Tie right after reset: req0 first, then req1
    do_reset();
    apply(1, 14, 6, 1, 12, 3, 1, 1);
    check_eq("tie_first_y", {24'd0, rsp_y}, 84);
    check_eq("tie_first_id", {31'd0, rsp_id}, 0);
    apply(1, 14, 6, 1, 12, 3, 1, 1);
    check_eq("tie_second_y", {24'd0, rsp_y}, 36);
    check_eq("tie_second_id", {31'd0, rsp_id}, 1);

    // Stall with 9x5 held, requesters waiting with other operands
    do_reset();
    apply(1, 9, 5, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      apply(1, 7, 7, 1, 3, 3, 0, 1);
      check_eq("stall_y", {24'd0, rsp_y}, 45);
    end
    apply(1, 7, 7, 1, 3, 3, 1, 1);
    check_eq("stall_release_y", {24'd0, rsp_y}, 9);
    apply(0, 0, 0, 0, 0, 0, 1, 1);
    check_eq("drain_valid", {31'd0, rsp_valid}, 0);

    // Operand boundaries
    apply(1, 15, 15, 0, 0, 0, 1, 1);
    check_eq("max_y", {24'd0, rsp_y}, 225);
    apply(0, 0, 0, 1, 0, 13, 1, 1);
    check_eq("zero_y", {24'd0, rsp_y}, 0);

    // Counter wrap on req1
    do_reset();
    for (int i = 0; i < 256; i++)
      apply(0, 0, 0, 1, 4'(i), 4'(i >> 4), 1, 1);
    check_eq("cnt1_wrap", {24'd0, cnt1}, 0);

    // Reset while a response is stalled, then a tie goes to req0
    apply(1, 5, 5, 0, 0, 0, 0, 1);
    apply(1, 6, 6, 0, 0, 0, 0, 1);
    apply(1, 6, 6, 1, 2, 2, 0, 0);
    check_eq("rst_stall_valid", {31'd0, rsp_valid}, 0);
    check_eq("rst_stall_cnt1", {24'd0, cnt1}, 0);
    apply(1, 3, 4, 1, 2, 2, 1, 1);
    check_eq("rst_tie_id", {31'd0, rsp_id}, 0);
    check_eq("rst_tie_y", {24'd0, rsp_y}, 12);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      apply($urandom_range(0, 1) == 1, 4'($urandom), 4'($urandom),
            $urandom_range(0, 1) == 1, 4'($urandom), 4'($urandom),
            $urandom_range(0, 9) < 7, $urandom_range(0, 49) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
